spmv_row_accumulator: RTL and testbench
=======================================

# spmv_row_accumulator

Row-wise reduction stage that sits directly downstream of the SpMV multiply/merge path and directly upstream of the pipelined FP adder. It consumes a stream of (row index, FP32 partial product) pairs ordered by row. It sums consecutive same-row values through the pipelined adder, hiding the adder latency with a stall-based hazard scheme, and emits one (row, sum) result per distinct row run.

## Interface
Parameters:
- `NUM_STG_ADDER_PIPE`, default `` `NUM_STG_ADDER_PIPE ``: adder output register stages; adder latency is L = NUM_STG_ADDER_PIPE + 1.
- `ROW_WIDTH`, default 32: row index width.
- `DATA_WIDTH`, default `` `DATA_PRECISION `` (32): FP32 value width.

Ports:
- `clk`, in, 1: single clock; all logic on posedge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: input element valid.
- `in_ready`, out, 1: block accepts the element this cycle.
- `in_row`, in, ROW_WIDTH: row index of the element.
- `in_val`, in, DATA_WIDTH: FP32 partial product.
- `in_last`, in, 1: final element of the stream; forces a flush.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_row`, out, ROW_WIDTH: row of the completed sum.
- `out_val`, out, DATA_WIDTH: FP32 row sum.
- `out_last`, out, 1: the result is the last of the stream.

## Operation
- Handshakes are valid/ready. A transfer occurs when valid && ready. Input fields must be held stable while in_valid is high and in_ready is low.
- Holding state: acc_row, acc_val, acc_last; out register {out_row, out_val, out_last, out_valid}; wait counter cnt (width clog2(L+1)).
- Adder instance: aclr = {rst, rst}, ena = 1. ax = acc_val, ay = in_val are registered inside the adder at issue; the result is valid exactly L cycles after the issue cycle.
- Out register is free when !out_valid || out_ready.
- FSM states and transitions:
  - IDLE: in_ready = 1. On accept, load acc_row, acc_val, acc_last from the input. Go to EMIT if in_last is set, otherwise go to ACCUM.
  - ACCUM: in_ready = out-register-free.
    - Accept with in_row == acc_row: issue the add, set acc_last <= in_last, set cnt <= L, go to WAIT.
    - Accept with in_row != acc_row: move acc into the out register with out_last = 0. Load the new element into acc. Go to EMIT if in_last is set, otherwise stay in ACCUM.
  - WAIT: in_ready = 0. Decrement cnt each cycle. When cnt == 1, capture acc_val <= adder result. Then go to EMIT if acc_last is set, otherwise go to ACCUM.
  - EMIT: in_ready = 0. When the out register is free, move acc into it with out_last = 1 and go to IDLE.
- Arithmetic:
  - Summation order is strictly left-to-right in arrival order.
  - Rounding is round-to-nearest, as set inside the adder.
  - No bits are added beyond DATA_WIDTH.
  - Row equality is an exact ROW_WIDTH compare.
- Rows are not required to be contiguous or increasing. Any row change closes the current run, so a row that reappears later produces a second output.
- A single-element row outputs in_val bit-exact, with no adder pass.

## Timing
- Reset values: in_ready = 0 while rst is high, 1 on the first cycle after rst is released (state IDLE). out_valid, out_row, out_val and out_last are 0. cnt = 0, acc = 0.
- Reset mid-operation (including in WAIT) discards the in-flight add and any held result. The adder pipeline is cleared by its aclr.
- Same-row throughput: one element per L+1 cycles (accept cycle plus L wait cycles).
- Row-change throughput: one element per cycle when the out register is free.
- The out register holds its contents while out_valid && !out_ready. ACCUM row changes and EMIT stall under that condition.
- Simultaneous events: out_ready pop and new push in the same cycle is legal. The out register is overwritten with no bubble.
- in_last on a row-change element: the previous row is emitted first (out_last = 0), then the new row is emitted in EMIT (out_last = 1). Minimum 2 output beats.

## Structure
- Shared package `spmv_acc_pkg`: state enum typedef (IDLE, ACCUM, WAIT, EMIT) and a result struct typedef {row, val, last}.
- Latency constant L is a localparam derived from NUM_STG_ADDER_PIPE.
- The only sub-module is the existing pipelined FP adder (`single_adder_pipe3`). Everything else is inline.

## Test plan
- Row 5: 1.0 (0x3F800000), 2.0 (0x40000000) with last -> one beat {5, 0x40400000, last = 1}. Second element accepted exactly L+1 cycles before EMIT.
- Rows 1, 2, 3, one value each (0.5, 1.5, 3.0), last on row 3 -> three beats with bit-exact values. Back-to-back acceptance every cycle with out_ready = 1.
- Row 7 ×4 of 1.0, then row 8 of 2.0 with last -> {7, 0x40800000, 0}, {8, 0x40000000, 1}. in_ready is low for L cycles after each same-row accept.
- out_ready held 0 for 10 cycles during rows 1, 2, 3 -> out register holds {1, ...}, in_ready = 0, no beat lost or duplicated.
- rst asserted in the middle of WAIT -> on the next cycle out_valid = 0 and in_ready = 0. Then in_ready = 1 and a fresh row-9 stream of 1.0 + 1.0 + last returns {9, 0x40000000, 1}.
- Row 4 value, row 6 value, row 4 value (non-contiguous) -> three separate beats with row 4 output twice.

Source files
------------

// File: rtl/spmv_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spmv_acc_pkg
// Purpose : Shared types for the SpMV row accumulator: FSM state encoding,
//           the (row, value, last) result record and the adder-latency
//           helper. Also provides fallback values for the build-wide
//           adder-depth and precision macros.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================

`ifndef NUM_STG_ADDER_PIPE
`define NUM_STG_ADDER_PIPE 3
`endif
`ifndef DATA_PRECISION
`define DATA_PRECISION 32
`endif

package spmv_acc_pkg;

    localparam int ACC_ROW_WIDTH  = 32;
    localparam int ACC_DATA_WIDTH = `DATA_PRECISION;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EMIT  = 2'd3
    } acc_state_e;

    // One row result. Used both for the running accumulator and for the
    // output register, so a hand-off between them is a single assignment.
    typedef struct packed {
        logic [ACC_ROW_WIDTH-1:0]  row;
        logic [ACC_DATA_WIDTH-1:0] val;
        logic                      last;
    } acc_result_t;

    // The adder registers its operands once, then adds num_stg output stages.
    function automatic int adder_latency(input int num_stg);
        return num_stg + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/single_adder_pipe3.sv
`default_nettype none
// ============================================================================
// Module  : single_adder_pipe3
// Purpose : Pipelined IEEE-754 binary32 adder, round-to-nearest-even.
//           Operands are registered, summed combinationally, then passed
//           through NUM_STG output register stages: result is valid
//           NUM_STG+1 cycles after the operands are presented.
//           Subnormal inputs and results are flushed to signed zero.
// Ports   : clk    - clock
//           aclr   - [0] clears operand regs, [1] clears output stages
//                    (synchronous)
//           ena    - pipeline advance enable
//           ax, ay - operands
//           result - sum
// Revision: 1.0 - initial release
// ============================================================================

module single_adder_pipe3 #(
    parameter int NUM_STG = 3
) (
    input  logic        clk,
    input  logic [1:0]  aclr,
    input  logic        ena,
    input  logic [31:0] ax,
    input  logic [31:0] ay,
    output logic [31:0] result
);

    logic [31:0] ax_q, ay_q;
    logic [31:0] w_sum;
    logic [31:0] pipe_q [NUM_STG];

    always_ff @(posedge clk) begin
        if (aclr[0]) begin
            ax_q <= '0;
            ay_q <= '0;
        end else if (ena) begin
            ax_q <= ax;
            ay_q <= ay;
        end
    end

    logic        w_swap, w_sub, w_lost, w_rnd;
    logic [31:0] w_big, w_sml;
    logic [7:0]  w_e_big, w_e_sml, w_d;
    logic [23:0] w_m_big, w_m_sml;
    logic [26:0] w_x_sml, w_sh, w_al, w_n;
    logic [27:0] w_s;
    logic [24:0] w_m;
    logic [4:0]  w_lz;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    int          w_e;

    always_comb begin
        w_swap  = (ay_q[30:0] > ax_q[30:0]);
        w_big   = w_swap ? ay_q : ax_q;
        w_sml   = w_swap ? ax_q : ay_q;
        w_e_big = w_big[30:23];
        w_e_sml = w_sml[30:23];
        w_m_big = (w_e_big != 8'd0) ? {1'b1, w_big[22:0]} : 24'd0;
        w_m_sml = (w_e_sml != 8'd0) ? {1'b1, w_sml[22:0]} : 24'd0;
        w_d     = w_e_big - w_e_sml;

        // Align the smaller operand with guard/round/sticky bits; anything
        // shifted out is folded into the sticky bit.
        w_x_sml = {w_m_sml, 3'b000};
        w_sh    = w_x_sml >> w_d;
        w_lost  = |(w_x_sml & ~({27{1'b1}} << w_d));
        w_al    = {w_sh[26:1], w_sh[0] | w_lost};

        w_sub = w_big[31] ^ w_sml[31];
        w_s   = w_sub ? ({1'b0, w_m_big, 3'b000} - {1'b0, w_al})
                      : ({1'b0, w_m_big, 3'b000} + {1'b0, w_al});

        w_lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (w_s[i]) w_lz = 5'(26 - i);
        end

        if (w_s[27]) begin
            w_n = {w_s[27:2], w_s[1] | w_s[0]};
            w_e = int'(w_e_big) + 1;
        end else begin
            w_n = w_s[26:0] << w_lz;
            w_e = int'(w_e_big) - int'(w_lz);
        end

        // Round to nearest, ties to even.
        w_rnd = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
        w_m   = {1'b0, w_n[26:3]} + {24'd0, w_rnd};
        if (w_m[24]) begin
            w_m = w_m >> 1;
            w_e = w_e + 1;
        end

        w_a_nan = (ax_q[30:23] == 8'hFF) && (ax_q[22:0] != 23'd0);
        w_b_nan = (ay_q[30:23] == 8'hFF) && (ay_q[22:0] != 23'd0);
        w_a_inf = (ax_q[30:23] == 8'hFF) && (ax_q[22:0] == 23'd0);
        w_b_inf = (ay_q[30:23] == 8'hFF) && (ay_q[22:0] == 23'd0);

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (ax_q[31] != ay_q[31])))
            w_sum = 32'h7FC00000;
        else if (w_a_inf)
            w_sum = ax_q;
        else if (w_b_inf)
            w_sum = ay_q;
        else if (w_s == 28'd0)
            // Exact cancellation gives +0; only -0 + -0 keeps the sign.
            w_sum = {w_big[31] & w_sml[31], 31'd0};
        else if (w_e <= 0 || !w_m[23])
            w_sum = {w_big[31], 31'd0};
        else if (w_e >= 255)
            w_sum = {w_big[31], 8'hFF, 23'd0};
        else
            w_sum = {w_big[31], 8'(w_e), w_m[22:0]};
    end

    generate
        for (genvar k = 0; k < NUM_STG; k++) begin : g_stage
            always_ff @(posedge clk) begin
                if (aclr[1]) begin
                    pipe_q[k] <= '0;
                end else if (ena) begin
                    if (k == 0) pipe_q[k] <= w_sum;
                    else        pipe_q[k] <= pipe_q[(k == 0) ? 0 : k-1];
                end
            end
        end
    endgenerate

    assign result = pipe_q[NUM_STG-1];

endmodule

`default_nettype wire

// File: rtl/spmv_row_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : spmv_row_accumulator
// Purpose : Sums runs of consecutive same-row FP32 partial products through
//           a pipelined adder and emits one (row, sum) result per run.
//           A same-row element stalls the input for the adder latency; a row
//           change hands the finished run to the output register directly.
// Ports   : clk, rst                       - clock, sync active-high reset
//           in_valid/in_ready              - input handshake
//           in_row, in_val, in_last        - element row, value, end-of-stream
//           out_valid/out_ready            - output handshake
//           out_row, out_val, out_last     - completed row sum, end-of-stream
// Revision: 1.0 - initial release
// ============================================================================

`ifndef NUM_STG_ADDER_PIPE
`define NUM_STG_ADDER_PIPE 3
`endif
`ifndef DATA_PRECISION
`define DATA_PRECISION 32
`endif

module spmv_row_accumulator
    import spmv_acc_pkg::*;
#(
    parameter int NUM_STG_ADDER_PIPE = `NUM_STG_ADDER_PIPE,
    // Widths must match the result record in spmv_acc_pkg.
    parameter int ROW_WIDTH          = ACC_ROW_WIDTH,
    parameter int DATA_WIDTH         = `DATA_PRECISION
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROW_WIDTH-1:0]  in_row,
    input  logic [DATA_WIDTH-1:0] in_val,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ROW_WIDTH-1:0]  out_row,
    output logic [DATA_WIDTH-1:0] out_val,
    output logic                  out_last
);

    localparam int L     = adder_latency(NUM_STG_ADDER_PIPE);
    localparam int CNT_W = $clog2(L + 1);

    acc_state_e         state_q, state_d;
    acc_result_t        acc_q, acc_d;
    acc_result_t        out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               w_in_ready;
    logic               w_out_free;
    logic [DATA_WIDTH-1:0] w_add_res;

    single_adder_pipe3 #(
        .NUM_STG (NUM_STG_ADDER_PIPE)
    ) u_adder (
        .clk    (clk),
        .aclr   ({rst, rst}),
        .ena    (1'b1),
        .ax     (acc_q.val),
        .ay     (in_val),
        .result (w_add_res)
    );

    assign w_out_free = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_d       = out_q;
        // A pending result drains whenever downstream accepts it.
        out_valid_d = out_valid_q && !out_ready;
        cnt_d       = cnt_q;
        w_in_ready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = '{row: in_row, val: in_val, last: in_last};
                    state_d = in_last ? ST_EMIT : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                w_in_ready = w_out_free;
                if (in_valid && w_out_free) begin
                    if (in_row == acc_q.row) begin
                        // Operands are captured by the adder this cycle.
                        acc_d.last = in_last;
                        cnt_d      = CNT_W'(L);
                        state_d    = ST_WAIT;
                    end else begin
                        out_d       = '{row: acc_q.row, val: acc_q.val, last: 1'b0};
                        out_valid_d = 1'b1;
                        acc_d       = '{row: in_row, val: in_val, last: in_last};
                        state_d     = in_last ? ST_EMIT : ST_ACCUM;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    acc_d.val = w_add_res;
                    state_d   = acc_q.last ? ST_EMIT : ST_ACCUM;
                end
            end
            ST_EMIT: begin
                if (w_out_free) begin
                    out_d       = '{row: acc_q.row, val: acc_q.val, last: 1'b1};
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    // Held low throughout reset regardless of the state register.
    assign in_ready  = w_in_ready && !rst;
    assign out_valid = out_valid_q;
    assign out_row   = out_q.row;
    assign out_val   = out_q.val;
    assign out_last  = out_q.last;

endmodule

`default_nettype wire

// File: tb/tb_spmv_row_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_spmv_row_accumulator
// Purpose : Directed self-checking bench for spmv_row_accumulator with
//           hand-computed FP32 row sums and handshake timing.
// Revision: 1.0 - initial release
// ============================================================================

module tb_spmv_row_accumulator;

    localparam int L = 4;   // three adder output stages plus operand register

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [31:0] in_row, in_val;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_row, out_val;

    always #5 clk = ~clk;

    spmv_row_accumulator #(
        .NUM_STG_ADDER_PIPE (3),
        .ROW_WIDTH          (32),
        .DATA_WIDTH         (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .in_val    (in_val),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_val   (out_val),
        .out_last  (out_last)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [64:0] beats [$];
    logic [64:0] exp_q [$];

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            beats.push_back({out_row, out_val, out_last});
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one element and hold it until accepted. Returns the number of
    // cycles in_ready was low and the cycle index of the accept.
    task automatic send(input logic [31:0] row, input logic [31:0] val, input logic last,
                        output int waits, output int acc_cyc);
        in_row   = row;
        in_val   = val;
        in_last  = last;
        in_valid = 1'b1;
        waits    = 0;
        acc_cyc  = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc;
                break;
            end
            waits++;
        end
        if (acc_cyc < 0) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for the expected beats, then compare count and contents.
    task automatic drain(input string tag);
        int n;
        n = exp_q.size();
        for (int k = 0; k < 100 && beats.size() < n; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk({tag, "_nbeats"}, beats.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < beats.size())
                chk($sformatf("%s_beat%0d", tag, i), beats[i], exp_q[i]);
        end
        beats.delete();
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int w, a, t;
    int w3;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_row = '0; in_val = '0; in_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_row",   out_row,   0);
        chk("rst_out_val",   out_val,   0);
        chk("rst_out_last",  out_last,  0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Row 5: 1.0 + 2.0 = 3.0; emit latency from the second accept
        send(32'd5, 32'h3F800000, 1'b0, w, a);
        send(32'd5, 32'h40000000, 1'b1, w, a);
        chk("t1_w2", w, 0);
        t = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid) begin
                t = cyc;
                break;
            end
        end
        chk("t1_emit_lat", t - a, L + 2);
        exp_q.push_back({32'd5, 32'h40400000, 1'b1});
        drain("t1");

        // Rows 1,2,3 single values back to back
        send(32'd1, 32'h3F000000, 1'b0, w, a); chk("t2_w1", w, 0);
        send(32'd2, 32'h3FC00000, 1'b0, w, a); chk("t2_w2", w, 0);
        send(32'd3, 32'h40400000, 1'b1, w, a); chk("t2_w3", w, 0);
        exp_q.push_back({32'd1, 32'h3F000000, 1'b0});
        exp_q.push_back({32'd2, 32'h3FC00000, 1'b0});
        exp_q.push_back({32'd3, 32'h40400000, 1'b1});
        drain("t2");

        // Row 7 x4 of 1.0, then row 8 of 2.0 with last
        send(32'd7, 32'h3F800000, 1'b0, w, a);
        send(32'd7, 32'h3F800000, 1'b0, w, a); chk("t3_w2", w, 0);
        send(32'd7, 32'h3F800000, 1'b0, w, a); chk("t3_w3", w, L);
        send(32'd7, 32'h3F800000, 1'b0, w, a); chk("t3_w4", w, L);
        send(32'd8, 32'h40000000, 1'b1, w, a); chk("t3_w8", w, L);
        exp_q.push_back({32'd7, 32'h40800000, 1'b0});
        exp_q.push_back({32'd8, 32'h40000000, 1'b1});
        drain("t3");

        // Backpressure: out_ready low for 10 cycles during rows 1,2,3
        out_ready = 1'b0;
        send(32'd1, 32'h3F000000, 1'b0, w, a);
        send(32'd2, 32'h3FC00000, 1'b0, w, a);
        fork
            send(32'd3, 32'h40400000, 1'b1, w3, a);
            begin
                repeat (10) @(negedge clk);
                chk("t4_hold_valid", out_valid, 1);
                chk("t4_hold_row",   out_row,   1);
                chk("t4_hold_val",   out_val,   32'h3F000000);
                chk("t4_in_ready",   in_ready,  0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        chk("t4_stalled", w3 >= 10, 1);
        exp_q.push_back({32'd1, 32'h3F000000, 1'b0});
        exp_q.push_back({32'd2, 32'h3FC00000, 1'b0});
        exp_q.push_back({32'd3, 32'h40400000, 1'b1});
        drain("t4");

        // Reset in the middle of WAIT, then a fresh row-9 stream
        send(32'd9, 32'h3F800000, 1'b0, w, a);
        send(32'd9, 32'h40400000, 1'b0, w, a);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_in_ready",  in_ready,  0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_idle_ready", in_ready, 1);
        @(posedge clk); #1;
        send(32'd9, 32'h3F800000, 1'b0, w, a);
        send(32'd9, 32'h3F800000, 1'b1, w, a);
        exp_q.push_back({32'd9, 32'h40000000, 1'b1});
        drain("t5");

        // Non-contiguous rows: 4, 6, 4
        send(32'd4, 32'h3F800000, 1'b0, w, a);
        send(32'd6, 32'h40000000, 1'b0, w, a);
        send(32'd4, 32'h3F000000, 1'b1, w, a);
        exp_q.push_back({32'd4, 32'h3F800000, 1'b0});
        exp_q.push_back({32'd6, 32'h40000000, 1'b0});
        exp_q.push_back({32'd4, 32'h3F000000, 1'b1});
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
